tank_sprite_fetch: RTL

- Upstream pixel-fetch stage for the tank sprite palette lookup.
- Takes the VGA draw coordinates and the tank position, hit-tests the sprite box and addresses the 4-bit-per-pixel sprite ROM.
- Returns the ROM's colour index, pipeline-aligned with a hit/opaque flag, to the palette stage that maps index to 12-bit RGB.
- Also owns tread-animation frame sequencing and tear-free position latching at vsync.

---
 rtl/tank_sprite_fetch.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/tank_sprite_fetch.sv
// Tank sprite pixel fetch: vsync-latched hit test, sprite ROM addressing and tread animation.
// Optional horizontal mirroring is enabled by defining TANK_SPRITE_MIRROR_EN.
module tank_sprite_fetch #(
  parameter int unsigned SPR_W           = 32,
  parameter int unsigned SPR_H           = 32,
  parameter int unsigned NUM_FRAMES      = 4,
  parameter int unsigned FRAME_DIV       = 8,
  parameter int unsigned TRANSPARENT_IDX = 0,
  localparam int unsigned ADDR_W         = $clog2(NUM_FRAMES * SPR_W * SPR_H),
  localparam int unsigned FRM_W          = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vsync_pulse_i,
  input  logic              moving_i,
  input  logic              mirror_x_i,
  input  logic [9:0]        pos_x_i,
  input  logic [9:0]        pos_y_i,
  input  logic [9:0]        draw_x_i,
  input  logic [9:0]        draw_y_i,
  input  logic              pix_valid_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [3:0]        rom_data_i,
  output logic [3:0]        pal_index_o,
  output logic              sprite_on_o,
  output logic              out_valid_o,
  output logic [FRM_W-1:0]  frame_o
);

  localparam int unsigned DX_W  = $clog2(SPR_W);
  localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  typedef enum logic {S_IDLE, S_ANIM} state_e;

  state_e             state_q, state_d;
  logic [FRM_W-1:0]   frame_q, frame_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [9:0]         sx_q, sy_q;
  logic [9:0]         sx_c, sy_c;
  logic               hit_c;
  logic [DX_W-1:0]    dx_c, dx_addr_c;
  logic [9:0]         dy_c;
  logic [10:0]        x11_c, y11_c, sx11_c, sy11_c;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               valid1_q, hit1_q, valid2_q, hit2_q;
  logic [3:0]         pal_q, pal_d;
  logic               on_q, on_d, out_valid_q;

  // Animation FSM: only advances on a vsync strobe
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    div_d   = div_q;
    if (vsync_pulse_i) begin
      case (state_q)
        S_IDLE: begin
          frame_d = '0;
          div_d   = '0;
          if (moving_i) state_d = S_ANIM;
        end
        S_ANIM: begin
          if (!moving_i) begin
            state_d = S_IDLE;
            frame_d = '0;
            div_d   = '0;
          end else if (div_q == DIV_W'(FRAME_DIV - 1)) begin
            div_d   = '0;
            frame_d = (frame_q == FRM_W'(NUM_FRAMES - 1)) ? '0 : frame_q + FRM_W'(1);
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A pixel coincident with vsync already sees the newly latched position
  assign sx_c = vsync_pulse_i ? pos_x_i : sx_q;
  assign sy_c = vsync_pulse_i ? pos_y_i : sy_q;

`ifdef TANK_SPRITE_MIRROR_EN
  logic mir_q, mir_c;
  assign mir_c = vsync_pulse_i ? mirror_x_i : mir_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              mir_q <= 1'b0;
    else if (vsync_pulse_i) mir_q <= mirror_x_i;
  end
`else
  logic unused_mirror;
  assign unused_mirror = mirror_x_i;
`endif

  // Hit test in 11 bits so a box near the right/bottom edge does not wrap
  always_comb begin
    x11_c  = {1'b0, draw_x_i};
    y11_c  = {1'b0, draw_y_i};
    sx11_c = {1'b0, sx_c};
    sy11_c = {1'b0, sy_c};
    hit_c  = pix_valid_i
           & (x11_c >= sx11_c) & (x11_c < sx11_c + 11'(SPR_W))
           & (y11_c >= sy11_c) & (y11_c < sy11_c + 11'(SPR_H));
    dx_c   = DX_W'(draw_x_i - sx_c);
    dy_c   = draw_y_i - sy_c;
`ifdef TANK_SPRITE_MIRROR_EN
    dx_addr_c = mir_c ? (DX_W'(SPR_W - 1) - dx_c) : dx_c;
`else
    dx_addr_c = dx_c;
`endif
    rom_addr_d = '0;
    if (hit_c)
      rom_addr_d = ADDR_W'(frame_d) * ADDR_W'(SPR_W * SPR_H)
                 + ADDR_W'(dy_c) * ADDR_W'(SPR_W)
                 + ADDR_W'(dx_addr_c);
  end

  always_comb begin
    pal_d = hit2_q ? rom_data_i : 4'(TRANSPARENT_IDX);
    on_d  = valid2_q & hit2_q & (rom_data_i != 4'(TRANSPARENT_IDX));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      frame_q     <= '0;
      div_q       <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      rom_addr_q  <= '0;
      valid1_q    <= 1'b0;
      hit1_q      <= 1'b0;
      valid2_q    <= 1'b0;
      hit2_q      <= 1'b0;
      pal_q       <= '0;
      on_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      div_q       <= div_d;
      if (vsync_pulse_i) begin
        sx_q <= pos_x_i;
        sy_q <= pos_y_i;
      end
      rom_addr_q  <= rom_addr_d;
      valid1_q    <= pix_valid_i;
      hit1_q      <= hit_c;
      valid2_q    <= valid1_q;
      hit2_q      <= hit1_q;
      pal_q       <= pal_d;
      on_q        <= on_d;
      out_valid_q <= valid2_q;
    end
  end

  assign rom_addr_o  = rom_addr_q;
  assign pal_index_o = pal_q;
  assign sprite_on_o = on_q;
  assign out_valid_o = out_valid_q;
  assign frame_o     = frame_q;

endmodule
